// File: rtl/serial_frame_rx_pkg.sv
// ============================================================================
// serial_pkg : shared state encoding and line levels for the framed serial RX
// Revision   : 1.0
// ============================================================================
`default_nettype none

package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PARITY = 3'd2,
        STOP   = 3'd3,
        BREAK  = 3'd4
    } rx_state_t;

    localparam logic IDLE_LVL  = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/serial_frame_rx_if.sv
// ============================================================================
// serial_frame_rx_if : received-word valid/ready port plus status/error flags
// Revision           : 1.0
// ============================================================================
`default_nettype none

interface serial_frame_rx_if #(
    parameter int DATA_W = 8
) ();

    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              busy;
    logic              frame_err;
    logic              parity_err;
    logic              overrun;

    modport master (
        input  out_ready,
        output out_data, out_valid, busy, frame_err, parity_err, overrun
    );

    modport slave (
        output out_ready,
        input  out_data, out_valid, busy, frame_err, parity_err, overrun
    );

endinterface

`default_nettype wire

// File: rtl/serial_frame_rx_sipo_shift_reg.sv
// ============================================================================
// sipo_shift_reg : LSB-first serial-in/parallel-out register with clear
// Revision       : 1.0
// ============================================================================
`default_nettype none

module sipo_shift_reg #(
    parameter int DATA_W = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_clr,
    input  wire logic              i_shift_en,
    input  wire logic              i_din,
    output logic      [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;

    // Bits enter at the MSB and walk down, so the first bit ends at bit 0.
    generate
        if (DATA_W == 1) begin : g_single
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)            r_q <= '0;
                else if (i_clr)      r_q <= '0;
                else if (i_shift_en) r_q <= i_din;
            end
        end else begin : g_wide
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)            r_q <= '0;
                else if (i_clr)      r_q <= '0;
                else if (i_shift_en) r_q <= {i_din, r_q[DATA_W-1:1]};
            end
        end
    endgenerate

    assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/serial_frame_rx.sv
// ============================================================================
// serial_frame_rx : framed serial receiver (start/data/parity/stop) with
//                   valid/ready word output and framing/parity/overrun flags
// Revision        : 1.0
// ============================================================================
`default_nettype none

module serial_frame_rx
    import serial_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit PARITY_EN = 1'b0
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         sin,
    serial_frame_rx_if.master rx
);

    localparam int                CNT_W      = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0]  c_last_bit = CNT_W'(DATA_W - 1);

    rx_state_t         r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_par_bad;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_frame_err;
    logic              r_parity_err;
    logic              r_overrun;

    logic [DATA_W-1:0] w_word;
    logic              w_clr;
    logic              w_shift_en;

    assign w_clr      = (r_state == IDLE) && (sin == START_LVL);
    assign w_shift_en = (r_state == DATA);

    sipo_shift_reg #(
        .DATA_W (DATA_W)
    ) u_sipo (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_clr),
        .i_shift_en (w_shift_en),
        .i_din      (sin),
        .o_q        (w_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_par_bad    <= 1'b0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;

            if (r_out_valid && rx.out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (sin == START_LVL) begin
                        r_state   <= DATA;
                        r_cnt     <= '0;
                        r_par_bad <= 1'b0;
                    end
                end
                DATA: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_last_bit) begin
                        r_state <= PARITY_EN ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    r_par_bad <= ^{w_word, sin};
                    r_state   <= STOP;
                end
                STOP: begin
                    if (sin == STOP_LVL) begin
                        r_state <= IDLE;
                        if (r_par_bad) begin
                            r_parity_err <= 1'b1;
                        end else if (!r_out_valid || rx.out_ready) begin
                            // A word accepted on this same edge frees the slot.
                            r_out_data  <= w_word;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_overrun <= 1'b1;
                        end
                    end else begin
                        r_frame_err <= 1'b1;
                        r_state     <= BREAK;
                    end
                end
                BREAK: begin
                    if (sin == IDLE_LVL) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rx.out_data   = r_out_data;
    assign rx.out_valid  = r_out_valid;
    assign rx.busy       = (r_state != IDLE);
    assign rx.frame_err  = r_frame_err;
    assign rx.parity_err = PARITY_EN & r_parity_err;
    assign rx.overrun    = r_overrun;

endmodule

`default_nettype wire

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Framed serial receiver: samples one serial line, one bit per clk, then deserializes start / data / optional parity / stop into a parallel word.
- Delivers each word on a valid/ready output port.
- Consumer end of the team's serial bit-stream path; the flip-flop-based serializer drives `sin`.
- Flags framing, parity and overrun errors.

Parameters:
- DATA_W, 8, data bits per frame, sent LSB first.
- PARITY_EN, 0, 1 = one even-parity bit follows the data bits.

Ports:
- clk  input  1  system clock; all sampling on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- sin  input  1  serial line; idles high; synchronous to clk.
- out_ready  input  1  consumer accepts out_data on a rising edge when out_valid=1.
- out_data  output  DATA_W  last received word.
- out_valid  output  1  word available; held until accepted.
- busy  output  1  high whenever state != IDLE.
- frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- parity_err  output  1  one-cycle pulse: parity mismatch (PARITY_EN=1 only; tied 0 otherwise).
- overrun  output  1  one-cycle pulse: completed word dropped because the previous word was still pending.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, shift register=0, bit counter=0.
  - out_data=0; out_valid, busy, frame_err, parity_err and overrun all 0.
  - Reset mid-frame discards the partial frame.
  - After reset releases, reception resumes at IDLE.
- States: IDLE, DATA, PARITY, STOP, BREAK.
- IDLE:
  - sin=0 at an edge is the start bit → DATA, counter=0.
  - sin=1 → stay in IDLE.
- DATA:
  - At each edge, sin is written into bit position `counter` of the shift register (LSB first), and the counter increments.
  - After the DATA_W-th data bit → PARITY if PARITY_EN=1, else STOP.
- PARITY:
  - Sample sin as p.
  - Even-parity rule: the XOR of the data bits and p must be 0.
  - Result is latched as a parity-bad flag → STOP.
- STOP, sin=1 (good stop bit):
  - If the parity-bad flag is set: parity_err pulses on the next cycle, the word is discarded → IDLE.
  - Otherwise the word is delivered per the output rules below → IDLE.
- STOP, sin=0:
  - frame_err pulses on the next cycle.
  - Word is discarded, and no parity_err is raised for this frame.
  - → BREAK.
- BREAK: remain until sin=1 → IDLE. A held-low line never starts a new frame.
- Latency:
  - Start bit sampled at edge E.
  - Stop bit sampled at edge E+DATA_W+1+PARITY_EN.
  - out_valid is high after that edge.
  - Back-to-back frames: the next start bit may be sampled at the edge immediately after the stop edge.
- Output handshake:
  - out_valid falls after an edge where out_valid=1 and out_ready=1, unless a new word is delivered at that same edge.
  - out_data is stable while out_valid=1.
- Delivery when out_valid=0, or out_valid=1 and out_ready=1 at the stop edge: out_data is loaded and out_valid=1.
- Delivery when out_valid=1 and out_ready=0 at the stop edge: new word dropped, out_data unchanged, overrun pulses for one cycle.
- Pulse rule: error pulses are registered and last exactly one cycle.
- Width rules:
  - Counter width = $clog2(DATA_W)+1.
  - DATA_W must be ≥ 1.
  - No arithmetic on data.

Decomposition:
- Shared package serial_pkg holds:
  - the state enum {IDLE, DATA, PARITY, STOP, BREAK};
  - localparams IDLE_LVL=1'b1, START_LVL=1'b0, STOP_LVL=1'b1.
- One natural sub-module, sipo_shift_reg: DATA_W-wide serial-in/parallel-out register with a shift-enable and a clear; the FSM controls it.
- Output handshake register and error pulses stay in the top module.

Test Plan:
- All bullets use DATA_W=8, PARITY_EN=0 and out_ready=1 unless stated.
- Frame 0xA5: sin=0,1,0,1,0,0,1,0,1,1 → out_data=8'hA5 and out_valid=1 after the 10th edge; busy is high for edges 1-10 only.
- Frame 0x3C with stop bit=0, sin held 0 for 5 more cycles, then 1 → frame_err pulses one cycle, out_valid stays 0, and state stays BREAK until sin=1 (no spurious frame).
- out_ready=0, send 0x11 then 0x22 back-to-back → out_data=8'h11 held and overrun pulses once at the second stop edge; raising out_ready then clears out_valid.
- PARITY_EN=1:
  - 0x07 with parity bit 1 → out_data=8'h07.
  - 0x07 with parity bit 0 → parity_err pulses, out_valid=0.
- Reset (rst=0) asserted after the 4th data bit of 0xFF, released, then 0x81 sent → all outputs 0 during reset; out_data=8'h81 with no error pulses.
